// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window sequencer.
package conv_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned FLAG_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } conv_state_e;

    // Flags travelling alongside the multiply-add tree pipeline.
    typedef struct packed {
        logic valid;
        logic chan;
        logic done;
    } conv_flags_t;

    function automatic int unsigned clog2_min1(input int unsigned value);
        if (value <= 32'd1) begin
            return 32'd1;
        end
        return 32'($clog2(value));
    endfunction

endpackage

// File: rtl/conv_window_fsm_if.sv
// Handshake bundle between the row loader, the sequencer and the datapath.
interface conv_window_fsm_if;

    logic input_start;
    logic row_shift_in_rdy;
    logic sr_enable;
    logic shift_row_up;
    logic window_valid;
    logic chan_done;
    logic conv_done;
    logic busy;

    modport master (
        output input_start,
        output row_shift_in_rdy,
        input  sr_enable,
        input  shift_row_up,
        input  window_valid,
        input  chan_done,
        input  conv_done,
        input  busy
    );

    modport slave (
        input  input_start,
        input  row_shift_in_rdy,
        output sr_enable,
        output shift_row_up,
        output window_valid,
        output chan_done,
        output conv_done,
        output busy
    );

endinterface

// File: rtl/conv_delay_line.sv
// Free-running flag delay matching the multiply-add tree depth; clear flushes in-flight flags.
module conv_delay_line
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic [FLAG_W-1:0] din,
    output logic [FLAG_W-1:0] dout
);

    logic [DEPTH-1:0][FLAG_W-1:0] stage_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else if (clear) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_window_fsm.sv
// Sequences row shift registers over a multi-channel input volume and flags
// valid windows, channel ends and convolution end at the MA-tree output.
module conv_window_fsm
    import conv_pkg::*;
#(
    parameter int unsigned SR_WIDTH     = 4,
    parameter int unsigned NUM_SR_ROWS  = 4,
    parameter int unsigned KERNEL_W     = 2,
    parameter int unsigned KERNEL_H     = 2,
    parameter int unsigned STRIDE       = 1,
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned TREE_LATENCY = 4
) (
    input  logic          clock,
    input  logic          reset,
    conv_window_fsm_if.slave bus
);

    localparam int unsigned ROW_MAX = (NUM_SR_ROWS - KERNEL_H) / STRIDE + 1;
    localparam int unsigned COL_W   = clog2_min1(SR_WIDTH);
    localparam int unsigned ROW_W   = clog2_min1(ROW_MAX);
    localparam int unsigned CHAN_W  = clog2_min1(NUM_CHANNELS);
    localparam int unsigned PH_W    = clog2_min1(STRIDE);
    localparam int unsigned DRN_W   = clog2_min1(TREE_LATENCY);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SR_WIDTH - 1);
    localparam logic [COL_W-1:0]  COL_KMIN  = COL_W'(KERNEL_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROW_MAX - 1);
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(NUM_CHANNELS - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(STRIDE - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(TREE_LATENCY - 1);

    conv_state_e       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [DRN_W-1:0]  drain_q, drain_d;

    logic enable_c, last_col_c, last_row_c, last_chan_c, in_kernel_c;
    logic valid_pre_c, chan_pre_c, done_pre_c;
    conv_flags_t flags_pre_c, flags_q;

    assign enable_c    = bus.row_shift_in_rdy & (state_q == ST_RUN);
    assign last_col_c  = (col_q == COL_LAST);
    assign last_row_c  = (row_q == ROW_LAST);
    assign last_chan_c = (chan_q == CHAN_LAST);
    assign in_kernel_c = (col_q >= COL_KMIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            chan_q  <= '0;
            phase_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            chan_q  <= chan_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        chan_d  = chan_q;
        phase_d = phase_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (enable_c) begin
                    if (last_col_c) begin
                        col_d   = '0;
                        phase_d = '0;
                        if (last_row_c) begin
                            row_d = '0;
                            if (last_chan_c) begin
                                chan_d  = '0;
                                state_d = ST_DRAIN;
                            end else begin
                                chan_d = chan_q + CHAN_W'(1);
                            end
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                        // Column stride: only windows on phase 0 are kept.
                        if (in_kernel_c) begin
                            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_LAST) begin
                    drain_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            default: begin
            end
        endcase
        // Start restarts from any state, taking priority over a finishing run.
        if (bus.input_start) begin
            state_d = ST_RUN;
            col_d   = '0;
            row_d   = '0;
            chan_d  = '0;
            phase_d = '0;
            drain_d = '0;
        end
    end

    assign valid_pre_c = enable_c & in_kernel_c & (phase_q == '0);
    assign chan_pre_c  = enable_c & last_col_c & last_row_c;
    assign done_pre_c  = chan_pre_c & last_chan_c;
    assign flags_pre_c = {valid_pre_c, chan_pre_c, done_pre_c};

    conv_delay_line #(
        .DEPTH (TREE_LATENCY)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .clear (bus.input_start),
        .din   (flags_pre_c),
        .dout  (flags_q)
    );

    assign bus.sr_enable    = enable_c;
    assign bus.shift_row_up = enable_c & last_col_c;
    assign bus.window_valid = flags_q.valid;
    assign bus.chan_done    = flags_q.chan;
    assign bus.conv_done    = flags_q.done;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_window_fsm.sv
// Directed bench for conv_window_fsm: defaults, column stride, multi-channel, stall, restart, reset.
module tb_conv_window_fsm;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    conv_window_fsm_if if0 ();
    conv_window_fsm_if if1 ();
    conv_window_fsm_if if2 ();

    conv_window_fsm dut0 (.clock(clock), .reset(reset), .bus(if0));
    conv_window_fsm #(.SR_WIDTH(6), .NUM_SR_ROWS(6), .STRIDE(2))
        dut1 (.clock(clock), .reset(reset), .bus(if1));
    conv_window_fsm #(.NUM_CHANNELS(3))
        dut2 (.clock(clock), .reset(reset), .bus(if2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic        s_en, s_sru, s_wv, s_ch, s_cd, s_busy;
    logic [63:0] wv_mask, ch_mask, cd_mask, en_mask, sru_mask;
    int          en_cnt, busy_fall;
    bit          sru_stray;

    task automatic drive(input int sel, input logic st, input logic rdy);
        case (sel)
            0: begin if0.input_start = st; if0.row_shift_in_rdy = rdy; end
            1: begin if1.input_start = st; if1.row_shift_in_rdy = rdy; end
            default: begin if2.input_start = st; if2.row_shift_in_rdy = rdy; end
        endcase
    endtask

    task automatic sample(input int sel);
        case (sel)
            0: {s_en, s_sru, s_wv, s_ch, s_cd, s_busy} = {if0.sr_enable, if0.shift_row_up,
                   if0.window_valid, if0.chan_done, if0.conv_done, if0.busy};
            1: {s_en, s_sru, s_wv, s_ch, s_cd, s_busy} = {if1.sr_enable, if1.shift_row_up,
                   if1.window_valid, if1.chan_done, if1.conv_done, if1.busy};
            default: {s_en, s_sru, s_wv, s_ch, s_cd, s_busy} = {if2.sr_enable, if2.shift_row_up,
                   if2.window_valid, if2.chan_done, if2.conv_done, if2.busy};
        endcase
    endtask

    // One cycle: inputs change on the falling edge, outputs are read 1 ns later.
    task automatic cyc(input int sel, input logic st, input logic rdy);
        @(negedge clock);
        drive(sel, st, rdy);
        #1;
        sample(sel);
    endtask

    // Runs ncyc cycles from a start at cycle 0 and records per-cycle output masks.
    task automatic run(input int sel, input int ncyc, input int lo_from, input int lo_to,
                       input int st2, input int st3);
        wv_mask = '0; ch_mask = '0; cd_mask = '0; en_mask = '0; sru_mask = '0;
        en_cnt = 0; busy_fall = -1; sru_stray = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            cyc(sel, (c == 0) || (c == st2) || (c == st3), !(c >= lo_from && c <= lo_to));
            if (s_en) begin
                en_cnt++;
                en_mask[c] = 1'b1;
                if (s_sru) sru_mask[en_cnt] = 1'b1;
            end else if (s_sru) begin
                sru_stray = 1'b1;
            end
            wv_mask[c] = s_wv;
            ch_mask[c] = s_ch;
            cd_mask[c] = s_cd;
            if (c >= 1 && !s_busy && busy_fall < 0) busy_fall = c;
        end
        drive(sel, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 1'b1);
        @(negedge clock);
        #1;
        for (int s = 0; s < 3; s++) begin
            sample(s);
            checks++;
            if ({s_en, s_sru, s_wv, s_ch, s_cd, s_busy} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %b expected 000000", s,
                         {s_en, s_sru, s_wv, s_ch, s_cd, s_busy});
            end
        end
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b1);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run(0, 20, -1, -1, -1, -1);
        checks++;
        if (en_cnt !== 12) begin errors++; $display("FAIL basic_en_cnt got %0d expected 12", en_cnt); end
        checks++;
        if (sru_mask !== 64'h1110 || sru_stray) begin
            errors++; $display("FAIL basic_shift_row_up got %h stray %0d expected 1110", sru_mask, sru_stray);
        end
        checks++;
        if (wv_mask !== 64'h1DDC0) begin errors++; $display("FAIL basic_window_valid got %h expected 1ddc0", wv_mask); end
        checks++;
        if (cd_mask !== (64'h1 << 16)) begin errors++; $display("FAIL basic_conv_done got %h expected 10000", cd_mask); end
        checks++;
        if (ch_mask !== (64'h1 << 16)) begin errors++; $display("FAIL basic_chan_done got %h expected 10000", ch_mask); end
        checks++;
        if (busy_fall !== 17) begin errors++; $display("FAIL basic_busy_fall got %0d expected 17", busy_fall); end
    endtask

    task automatic test_stride();
        run(1, 26, -1, -1, -1, -1);
        checks++;
        if (en_cnt !== 18) begin errors++; $display("FAIL stride_en_cnt got %0d expected 18", en_cnt); end
        checks++;
        if (sru_mask !== 64'h41040) begin errors++; $display("FAIL stride_shift_row_up got %h expected 41040", sru_mask); end
        checks++;
        if (wv_mask !== 64'h555540) begin errors++; $display("FAIL stride_window_valid got %h expected 555540", wv_mask); end
        checks++;
        if (cd_mask !== (64'h1 << 22)) begin errors++; $display("FAIL stride_conv_done got %h expected 400000", cd_mask); end
        checks++;
        if (busy_fall !== 23) begin errors++; $display("FAIL stride_busy_fall got %0d expected 23", busy_fall); end
    endtask

    task automatic test_channels();
        run(2, 45, -1, -1, -1, -1);
        checks++;
        if (en_cnt !== 36) begin errors++; $display("FAIL chan_en_cnt got %0d expected 36", en_cnt); end
        checks++;
        if ($countones(wv_mask) !== 27) begin
            errors++; $display("FAIL chan_window_count got %0d expected 27", $countones(wv_mask));
        end
        checks++;
        if (ch_mask !== ((64'h1 << 16) | (64'h1 << 28) | (64'h1 << 40))) begin
            errors++; $display("FAIL chan_chan_done got %h expected 10010010000", ch_mask);
        end
        checks++;
        if (cd_mask !== (64'h1 << 40)) begin errors++; $display("FAIL chan_conv_done got %h expected 10000000000", cd_mask); end
        checks++;
        if (busy_fall !== 41) begin errors++; $display("FAIL chan_busy_fall got %0d expected 41", busy_fall); end
    endtask

    task automatic test_stall();
        run(0, 24, 6, 8, -1, -1);
        checks++;
        if (en_cnt !== 12 || en_mask[8:6] !== 3'b000) begin
            errors++; $display("FAIL stall_sr_enable got cnt %0d mask %h expected 12 with cycles 6-8 low", en_cnt, en_mask);
        end
        checks++;
        if (sru_mask !== 64'h1110) begin errors++; $display("FAIL stall_shift_row_up got %h expected 1110", sru_mask); end
        checks++;
        if (wv_mask !== 64'hEE1C0) begin errors++; $display("FAIL stall_window_valid got %h expected ee1c0", wv_mask); end
        checks++;
        if (cd_mask !== (64'h1 << 19)) begin errors++; $display("FAIL stall_conv_done got %h expected 80000", cd_mask); end
        checks++;
        if (busy_fall !== 20) begin errors++; $display("FAIL stall_busy_fall got %0d expected 20", busy_fall); end
    endtask

    task automatic test_restart();
        int          wv_pos[$] = '{6, 7, 13, 14, 15, 17, 18, 19, 21,
                                   27, 28, 29, 31, 32, 33, 35, 36, 37};
        logic [63:0] exp_wv;
        exp_wv = '0;
        foreach (wv_pos[i]) exp_wv[wv_pos[i]] = 1'b1;
        run(0, 42, -1, -1, 7, 21);
        checks++;
        if (wv_mask !== exp_wv) begin errors++; $display("FAIL restart_window_valid got %h expected %h", wv_mask, exp_wv); end
        checks++;
        if ($countones(wv_mask[41:22]) !== 9) begin
            errors++; $display("FAIL restart_last_run_windows got %0d expected 9", $countones(wv_mask[41:22]));
        end
        checks++;
        if (cd_mask !== (64'h1 << 37) || ch_mask !== (64'h1 << 37)) begin
            errors++; $display("FAIL restart_done_flags got conv %h chan %h expected 2000000000", cd_mask, ch_mask);
        end
        checks++;
        if (en_cnt !== 31) begin errors++; $display("FAIL restart_en_cnt got %0d expected 31", en_cnt); end
        checks++;
        if (busy_fall !== 38) begin errors++; $display("FAIL restart_busy_fall got %0d expected 38", busy_fall); end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            // pass 0 stops at cycle 4 (RUN), pass 1 at cycle 14 (DRAIN, window in flight).
            run(0, (pass == 0) ? 5 : 15, -1, -1, -1, -1);
            checks++;
            if (s_busy !== 1'b1 || s_wv !== (pass == 1)) begin
                errors++; $display("FAIL reset_mid_pre%0d got busy %b valid %b expected 1 %0d", pass, s_busy, s_wv, pass);
            end
            #2 reset = 1'b1;
            #1 sample(0);
            checks++;
            if ({s_en, s_sru, s_wv, s_ch, s_cd, s_busy} !== 6'b0) begin
                errors++; $display("FAIL reset_mid_outputs%0d got %b expected 000000", pass,
                                   {s_en, s_sru, s_wv, s_ch, s_cd, s_busy});
            end
            @(negedge clock);
            reset = 1'b0;
            run(0, 20, -1, -1, -1, -1);
            checks++;
            if (wv_mask !== 64'h1DDC0 || cd_mask !== (64'h1 << 16) || busy_fall !== 17) begin
                errors++; $display("FAIL reset_mid_rerun%0d got wv %h cd %h busy_fall %0d expected 1ddc0 10000 17",
                                   pass, wv_mask, cd_mask, busy_fall);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_basic();
        test_stride();
        test_channels();
        test_stall();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
